// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter, 16x oversampled bit timing.
//
// Sends one frame per accepted start: a low start bit, N_BITS data bits LSB
// first, then a high stop period of SB_TICK oversampling ticks. One tick is
// BAUD_DIV clk cycles, so one bit lasts 16 * BAUD_DIV cycles.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst          asynchronous, active-high reset
//   i_tx_data    byte to send, sampled only on the accepting edge
//   is_tx_start  start request
//   o_tx         serial line, idle high
//   os_tx_done   one-cycle strobe in the first IDLE cycle after a frame
//   o_tx_busy    high from the accepting edge until the return to IDLE
//
// Handshake: is_tx_start acts as 'valid' and !o_tx_busy as 'ready'. A start
// seen at a rising edge while the FSM is in IDLE is accepted at that edge;
// starts seen in any other state are dropped without side effects. The
// done cycle is already IDLE, so a start there chains frames with no gap.

module uart_tx #(
  parameter int N_BITS   = 8,
  parameter int BAUD_DIV = 163,
  parameter int SB_TICK  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] i_tx_data,
  input  logic              is_tx_start,
  output logic              o_tx,
  output logic              os_tx_done,
  output logic              o_tx_busy
);

  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(N_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tick;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    tick   = (baud_q == BAUD_LAST);
    baud_d = tick ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (is_tx_start) begin
          state_d = ST_START;
          shift_d = i_tx_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          // Restarting the divider here makes the start bit exactly 16
          // ticks long no matter where the free-running count was.
          baud_d  = '0;
          s_d     = '0;
          n_d     = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_q == BIT_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = shift_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              shift_d = shift_q >> 1;
              n_d     = n_q + 1'b1;
              tx_d    = shift_d[0];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_q == STOP_LAST) begin
            state_d = ST_IDLE;
            s_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_tx       = tx_q;
  assign os_tx_done = done_q;
  assign o_tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with BAUD_DIV=4, SB_TICK=16,
// N_BITS=8: one bit is 64 clk cycles, one frame 640 cycles from the
// accepting edge to the done edge. Outputs are sampled 1 time unit after
// each rising edge; inputs are driven at the same point.

module tb_uart_tx;

  localparam int N_BITS   = 8;
  localparam int BAUD_DIV = 4;
  localparam int SB_TICK  = 16;
  localparam int BIT_CYC  = 16 * BAUD_DIV;
  localparam int FRAME    = (1 + N_BITS) * BIT_CYC + SB_TICK * BAUD_DIV;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_BITS-1:0] i_tx_data;
  logic              is_tx_start;
  logic              o_tx;
  logic              os_tx_done;
  logic              o_tx_busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .N_BITS  (N_BITS),
    .BAUD_DIV(BAUD_DIV),
    .SB_TICK (SB_TICK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tx_data  (i_tx_data),
    .is_tx_start(is_tx_start),
    .o_tx       (o_tx),
    .os_tx_done (os_tx_done),
    .o_tx_busy  (o_tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, o_tx, 1'b1);
    chk({tag, "_busy"}, o_tx_busy, 1'b0);
    chk({tag, "_done"}, os_tx_done, 1'b0);
  endtask

  // Present a start for exactly one rising edge.
  task automatic start_frame(input logic [7:0] data);
    i_tx_data   = data;
    is_tx_start = 1'b1;
    step();
    is_tx_start = 1'b0;
  endtask

  // Called just after the accepting edge. Checks every cycle of the frame,
  // scrambles i_tx_data throughout, optionally injects a start at cycle
  // 'inj' or holds start high, and optionally asserts reset at 'abort_at'.
  // Returns at the done sample point without taking another edge.
  task automatic run_frame(input logic [7:0] data, input int inj,
                           input logic [7:0] inj_data, input bit keep,
                           input int abort_at);
    int  b;
    logic e;
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_tx_async", o_tx, 1'b1);
        chk("abort_busy_async", o_tx_busy, 1'b0);
        chk("abort_done_async", os_tx_done, 1'b0);
        is_tx_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
          step();
          chk_idle("abort_in_rst");
        end
        is_tx_start = 1'b0;
        #2;
        rst = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
          step();
          chk_idle("abort_after_rst");
        end
        return;
      end
      b = c / BIT_CYC;
      if (b == 0)           e = 1'b0;
      else if (b == 1 + N_BITS) e = 1'b1;
      else                  e = data[b-1];
      chk("line", o_tx, e);
      chk("busy", o_tx_busy, 1'b1);
      chk("done_early", os_tx_done, 1'b0);
      is_tx_start = keep ? 1'b1 : (c == inj);
      i_tx_data   = (c == inj) ? inj_data : 8'($urandom);
      step();
    end
    chk("done_strobe", os_tx_done, 1'b1);
    chk("done_busy", o_tx_busy, 1'b0);
    chk("done_tx", o_tx, 1'b1);
  endtask

  logic [7:0] send_bytes [8];

  initial begin
    rst         = 1'b1;
    is_tx_start = 1'b0;
    i_tx_data   = 8'h00;

    // Reset: held 5 cycles with start requests that must be ignored.
    is_tx_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_tx_data = 8'($urandom);
      step();
      chk_idle("reset");
    end
    is_tx_start = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_idle("post_reset");
    end

    // Single frame 0xA5: line reads 0, 1,0,1,0,0,1,0,1, 1.
    start_frame(8'hA5);
    run_frame(8'hA5, -1, 8'h00, 1'b0, -1);
    step();
    chk_idle("a5_after_done");

    // Start with 0xFF requested mid-frame is dropped.
    start_frame(8'h0F);
    run_frame(8'h0F, 200, 8'hFF, 1'b0, -1);
    for (int k = 0; k < 2 * BIT_CYC; k++) begin
      step();
      chk_idle("busy_ignore_idle");
    end

    // Back-to-back: start in the done cycle begins 0x3C immediately.
    start_frame(8'h5A);
    run_frame(8'h5A, -1, 8'h00, 1'b0, -1);
    start_frame(8'h3C);
    run_frame(8'h3C, -1, 8'h00, 1'b0, -1);
    step();
    chk_idle("b2b_after_done");

    // Start held high throughout: a new frame begins at the done cycle.
    start_frame(8'hC3);
    run_frame(8'hC3, -1, 8'h00, 1'b1, -1);
    start_frame(8'h96);
    run_frame(8'h96, -1, 8'h00, 1'b0, -1);
    step();
    chk_idle("held_after_done");

    // Reset 300 cycles into a frame, then a clean 0x81 frame.
    start_frame(8'h55);
    run_frame(8'h55, -1, 8'h00, 1'b0, 300);
    start_frame(8'h81);
    run_frame(8'h81, -1, 8'h00, 1'b0, -1);
    step();
    chk_idle("rst_recover_after_done");

    // Byte stream: word 0x0000000F then counter 0xFFFFFFFF, MSB first.
    send_bytes[0] = 8'h00; send_bytes[1] = 8'h00;
    send_bytes[2] = 8'h00; send_bytes[3] = 8'h0F;
    send_bytes[4] = 8'hFF; send_bytes[5] = 8'hFF;
    send_bytes[6] = 8'hFF; send_bytes[7] = 8'hFF;
    start_frame(send_bytes[0]);
    for (int i = 0; i < 8; i++) begin
      run_frame(send_bytes[i], -1, 8'h00, 1'b0, -1);
      if (i < 7) start_frame(send_bytes[i+1]);
    end
    step();
    chk_idle("stream_after_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
